ram_word_reader: RTL

// - Downstream companion to the byte-splitting RAM writer. It reads back 16-bit words that were

---
 rtl/ram_word_reader_pkg.sv | 24 ++
 rtl/ram_word_reader.sv | 114 +++++++++++
 2 files changed

// File: rtl/ram_word_reader_pkg.sv
// Shared constants and state encoding for the byte-wide RAM word reader/writer pair.
package ram_word_reader_pkg;

  localparam int ADDR_W = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_HI  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_REQ_LO  = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Next byte address; arithmetic deliberately wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] inc);
    return a + inc;
  endfunction

endpackage

// File: rtl/ram_word_reader.sv
// Reads 16-bit words stored big-endian as byte pairs in byte-wide RAM and streams
// them out on a valid/ready interface, one outstanding RAM read at a time.
module ram_word_reader
  import ram_word_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] ramBase,
  input  logic [15:0]       wordCount,
  output logic              read,
  output logic [ADDR_W-1:0] ramAddress,
  input  logic [BYTE_W-1:0] ramDataIn,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [2:0]        lat;
  logic [BYTE_W-1:0] hi;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      read       <= 1'b0;
      ramAddress <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
      lat        <= '0;
      hi         <= '0;
    end else begin
      read <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy is still high during the done-pulse cycle, so start is ignored there
          busy <= 1'b0;
          if (start && !busy) begin
            addr      <= ramBase;
            remaining <= wordCount;
            busy      <= 1'b1;
            if (wordCount != 16'd0) begin
              state      <= ST_REQ_HI;
              read       <= 1'b1;
              ramAddress <= ramBase;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_REQ_HI: begin
          lat   <= '0;
          state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (lat == LAT_LAST) begin
            hi         <= ramDataIn;
            state      <= ST_REQ_LO;
            read       <= 1'b1;
            ramAddress <= addr_step(addr, 16'd1);
          end else begin
            lat <= lat + 3'd1;
          end
        end
        ST_REQ_LO: begin
          lat   <= '0;
          state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (lat == LAT_LAST) begin
            word_out   <= {hi, ramDataIn};
            word_valid <= 1'b1;
            addr       <= addr_step(addr, 16'd2);
            remaining  <= remaining - 16'd1;
            state      <= ST_OUT;
          end else begin
            lat <= lat + 3'd1;
          end
        end
        ST_OUT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (remaining != 16'd0) begin
              state      <= ST_REQ_HI;
              read       <= 1'b1;
              ramAddress <= addr;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
